// File: rtl/piano_note_scheduler_pkg.sv
// rtl/piano_note_scheduler_pkg.sv - shared state encoding and defaults for the piano note scheduler
//
// Purpose: scheduler state type, default key-bank geometry and a replay-state helper,
//          imported by the scheduler and its note buffer.
// Ports:   none (package).
package piano_note_scheduler_pkg;

    localparam int DEF_NUM_KEYS = 8;
    localparam int DEF_KEY_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LIVE     = 3'd1,
        ST_REP_NOTE = 3'd2,
        ST_REP_WAIT = 3'd3,
        ST_REP_GAP  = 3'd4
    } state_t;

    function automatic logic is_replay(input state_t s);
        return (s == ST_REP_NOTE) || (s == ST_REP_WAIT) || (s == ST_REP_GAP);
    endfunction

endpackage

// File: rtl/piano_note_scheduler_note_buffer.sv
// rtl/piano_note_scheduler_note_buffer.sv - DEPTH x KEY_W melody record buffer
//
// Purpose: register file holding recorded note indices. Synchronous write at the
//          current fill level, asynchronous read, clear, registered count and full flag.
// Ports:   iClk, iReset_n   clock, synchronous active-low reset (clears count/full only)
//          iClear           empty the buffer this cycle
//          iWrEn, iWrData   append a note (dropped when full)
//          iRdAddr, oRdData asynchronous read port
//          oCount, oFull    entries stored, buffer full
module piano_note_scheduler_note_buffer
    import piano_note_scheduler_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int KEY_W = DEF_KEY_W,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iClear,
    input  logic             iWrEn,
    input  logic [KEY_W-1:0] iWrData,
    input  logic [AW-1:0]    iRdAddr,
    output logic [KEY_W-1:0] oRdData,
    output logic [CW-1:0]    oCount,
    output logic             oFull
);

    logic [KEY_W-1:0] mem_q [DEPTH];
    logic [KEY_W-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    base_count;
    logic             full_q, full_d;

    // Clear is applied before the write so a same-cycle write lands at entry 0.
    // The fill level doubles as the write pointer.
    always_comb begin
        mem_d      = mem_q;
        base_count = iClear ? '0 : count_q;
        count_d    = base_count;
        if (iWrEn && (base_count < CW'(DEPTH))) begin
            mem_d[base_count[AW-1:0]] = iWrData;
            count_d                   = base_count + CW'(1);
        end
        full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge iClk) begin
        mem_q <= mem_d;
    end

    assign oRdData = mem_q[iRdAddr];
    assign oCount  = count_q;
    assign oFull   = full_q;

endmodule

// File: rtl/piano_note_scheduler.sv
// rtl/piano_note_scheduler.sv - shares one buzzer among the piano keys, records and replays melodies
//
// Purpose: selects the sounding note from key presses, drives the buzzer counter enable,
//          records pressed notes while iRecord is high and replays them with fixed timing.
// Ports:   iClk, iReset_n  clock, synchronous active-low reset
//          iKeys           debounced key levels, 1 = pressed
//          iRecord         record level; rising edge clears the buffer
//          iPlay           replay request, rising edge
//          iRing           buzzer tail still sounding
//          oCountEnable    hold note sounding
//          oNote           note index to tone generator
//          oBusy           replay in progress
//          oMemFull        record buffer full
//          oMemCount       entries stored
module piano_note_scheduler
    import piano_note_scheduler_pkg::*;
#(
    parameter int NUM_KEYS    = DEF_NUM_KEYS,
    parameter int KEY_W       = DEF_KEY_W,
    parameter int DEPTH       = 16,
    parameter int NOTE_CYCLES = 100000,
    parameter int GAP_CYCLES  = 50000,
    parameter int CNT_W       = 21
) (
    input  logic                       iClk,
    input  logic                       iReset_n,
    input  logic [NUM_KEYS-1:0]        iKeys,
    input  logic                       iRecord,
    input  logic                       iPlay,
    input  logic                       iRing,
    output logic                       oCountEnable,
    output logic [KEY_W-1:0]           oNote,
    output logic                       oBusy,
    output logic                       oMemFull,
    output logic [$clog2(DEPTH):0]     oMemCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t               state_q, state_d;
    logic [NUM_KEYS-1:0]  keys_q;
    logic                 record_q, play_q;
    logic [KEY_W-1:0]     note_q, note_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]     timer_q, timer_d;

    logic [NUM_KEYS-1:0]  press;
    logic                 any_press;
    logic [KEY_W-1:0]     press_idx, held_idx;
    logic                 record_rise, play_rise;
    logic                 buf_clear, buf_wr;
    logic [AW-1:0]        rd_addr;
    logic [KEY_W-1:0]     rd_data;
    logic [CW-1:0]        mem_count;
    logic                 mem_full;

    function automatic logic [KEY_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = KEY_W'(i);
        end
    endfunction

    assign press       = iKeys & ~keys_q;
    assign any_press   = |press;
    assign press_idx   = lowest_idx(press);
    assign held_idx    = lowest_idx(iKeys);
    assign record_rise = iRecord & ~record_q;
    assign play_rise   = iPlay & ~play_q;

    // Read address depends only on registered state so the read data can feed note_d
    // without a combinational loop: entry 0 when starting from IDLE, the next entry in GAP.
    assign rd_addr = (state_q == ST_REP_GAP) ?
                     ((ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1)) : '0;

    always_comb begin
        state_d   = state_q;
        note_d    = note_q;
        en_d      = en_q;
        busy_d    = busy_q;
        ptr_d     = ptr_q;
        buf_wr    = 1'b0;
        buf_clear = record_rise && !is_replay(state_q);

        case (state_q)
            ST_IDLE: begin
                if (any_press) begin
                    state_d = ST_LIVE;
                    note_d  = press_idx;
                    en_d    = 1'b1;
                    buf_wr  = iRecord;
                end else if (play_rise && (mem_count != '0)) begin
                    state_d = ST_REP_NOTE;
                    ptr_d   = '0;
                    note_d  = rd_data;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_LIVE: begin
                if (any_press) begin
                    note_d = press_idx;
                    buf_wr = iRecord;
                end else if (iKeys == '0) begin
                    // Leave oNote alone so the counter tail keeps the same pitch.
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end else if (!iKeys[note_q]) begin
                    note_d = held_idx;
                end
            end
            ST_REP_NOTE: begin
                if (timer_q == CNT_W'(NOTE_CYCLES - 1)) begin
                    en_d    = 1'b0;
                    state_d = ST_REP_WAIT;
                end
            end
            ST_REP_WAIT: begin
                if (!iRing) state_d = ST_REP_GAP;
            end
            ST_REP_GAP: begin
                if (timer_q == CNT_W'(GAP_CYCLES - 1)) begin
                    if ((CW'(ptr_q) + CW'(1)) == mem_count) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_REP_NOTE;
                        ptr_d   = ptr_q + AW'(1);
                        note_d  = rd_data;
                        en_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // A live press always wins over replay; the pressed note is not recorded.
        if (is_replay(state_q) && any_press) begin
            state_d = ST_LIVE;
            note_d  = press_idx;
            en_d    = 1'b1;
            busy_d  = 1'b0;
        end

        if ((state_d != state_q) || !((state_q == ST_REP_NOTE) || (state_q == ST_REP_GAP)))
            timer_d = '0;
        else
            timer_d = timer_q + CNT_W'(1);
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state_q  <= ST_IDLE;
            keys_q   <= '0;
            record_q <= 1'b0;
            play_q   <= 1'b0;
            note_q   <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            ptr_q    <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            keys_q   <= iKeys;
            record_q <= iRecord;
            play_q   <= iPlay;
            note_q   <= note_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
            timer_q  <= timer_d;
        end
    end

    piano_note_scheduler_note_buffer #(
        .DEPTH (DEPTH),
        .KEY_W (KEY_W)
    ) u_note_buffer (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .iClear   (buf_clear),
        .iWrEn    (buf_wr),
        .iWrData  (press_idx),
        .iRdAddr  (rd_addr),
        .oRdData  (rd_data),
        .oCount   (mem_count),
        .oFull    (mem_full)
    );

    assign oCountEnable = en_q;
    assign oNote        = note_q;
    assign oBusy        = busy_q;
    assign oMemFull     = mem_full;
    assign oMemCount    = mem_count;

endmodule

// File: tb/tb_piano_note_scheduler.sv
// tb/tb_piano_note_scheduler.sv - self-checking bench for piano_note_scheduler
module tb_piano_note_scheduler;

    localparam int NOTE_C = 4;
    localparam int GAP_C  = 2;
    localparam int DEP    = 4;

    localparam int M_IDLE = 0;
    localparam int M_LIVE = 1;
    localparam int M_NOTE = 2;
    localparam int M_WAIT = 3;
    localparam int M_GAP  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] keys;
    logic       rec, play;
    logic       ring = 1'b0;
    logic       en, busy, full;
    logic [2:0] note;
    logic [2:0] cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piano_note_scheduler #(
        .NUM_KEYS    (8),
        .KEY_W       (3),
        .DEPTH       (DEP),
        .NOTE_CYCLES (NOTE_C),
        .GAP_CYCLES  (GAP_C),
        .CNT_W       (4)
    ) dut (
        .iClk         (clk),
        .iReset_n     (rst_n),
        .iKeys        (keys),
        .iRecord      (rec),
        .iPlay        (play),
        .iRing        (ring),
        .oCountEnable (en),
        .oNote        (note),
        .oBusy        (busy),
        .oMemFull     (full),
        .oMemCount    (cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Buzzer stand-in: ring stays high while enabled and for two cycles after.
    int tail = 0;
    always @(posedge clk) begin
        #1;
        if (en === 1'b1) begin
            ring = 1'b1;
            tail = 2;
        end else if (tail > 0) begin
            tail--;
            ring = 1'b1;
        end else begin
            ring = 1'b0;
        end
    end

    // Behavioural model
    int         m_mode, m_note, m_ptr, m_left;
    bit         m_en, m_busy, chk_on = 0;
    int         m_buf[$];
    logic [7:0] p_keys;
    bit         p_rec, p_play;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        logic [7:0] pr;
        int  idx;
        bit  rec_ok, wr;
        if (!rst_n) begin
            m_mode = M_IDLE; m_note = 0; m_en = 0; m_busy = 0; m_ptr = 0; m_left = 0;
            m_buf.delete();
            p_keys = 0; p_rec = 0; p_play = 0;
            chk_on = 1;
        end else begin
            pr     = keys & ~p_keys;
            idx    = lowest(pr);
            rec_ok = (m_mode == M_IDLE) || (m_mode == M_LIVE);
            wr     = 0;
            if (rec_ok && rec && !p_rec) m_buf.delete();
            if (m_mode == M_IDLE) begin
                if (pr != 0) begin
                    m_mode = M_LIVE; m_note = idx; m_en = 1; wr = 1;
                end else if (play && !p_play && m_buf.size() > 0) begin
                    m_mode = M_NOTE; m_ptr = 0; m_note = m_buf[0]; m_en = 1; m_busy = 1;
                    m_left = NOTE_C;
                end
            end else if (m_mode == M_LIVE) begin
                if (pr != 0) begin
                    m_note = idx; wr = 1;
                end else if (keys == 0) begin
                    m_en = 0; m_mode = M_IDLE;
                end else if (!keys[m_note]) begin
                    m_note = lowest(keys);
                end
            end else if (pr != 0) begin
                m_mode = M_LIVE; m_note = idx; m_en = 1; m_busy = 0;
            end else if (m_mode == M_NOTE) begin
                m_left--;
                if (m_left == 0) begin m_en = 0; m_mode = M_WAIT; end
            end else if (m_mode == M_WAIT) begin
                if (!ring) begin m_mode = M_GAP; m_left = GAP_C; end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_ptr == m_buf.size() - 1) begin
                        m_mode = M_IDLE; m_busy = 0;
                    end else begin
                        m_ptr++; m_note = m_buf[m_ptr]; m_en = 1; m_mode = M_NOTE;
                        m_left = NOTE_C;
                    end
                end
            end
            if (wr && rec && m_buf.size() < DEP) m_buf.push_back(idx);
            p_keys = keys; p_rec = rec; p_play = play;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_en",    32'(en),   32'(m_en));
            chk("model_note",  32'(note), 32'(m_note));
            chk("model_busy",  32'(busy), 32'(m_busy));
            chk("model_count", 32'(cnt),  32'(m_buf.size()));
            chk("model_full",  32'(full), 32'(m_buf.size() == DEP));
        end
    end

    task automatic cyc(input logic [7:0] k, input logic r, input logic p);
        keys = k; rec = r; play = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int   seq[5] = '{3, 1, 4, 1, 5};
        int   exp4[4] = '{3, 1, 4, 1};
        int   got[$];
        bit   prev_en;
        bit   tr_en[20], tr_busy[20];
        int   tr_note[20];
        int   n;

        rst_n = 1'b0; keys = 0; rec = 0; play = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_en", 32'(en), 0);
        chk("reset_note", 32'(note), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_count", 32'(cnt), 0);
        chk("reset_full", 32'(full), 0);

        // Same-cycle press, release to held key, release all
        cyc(8'b0010_0100, 0, 0);
        chk("same_press_note", 32'(note), 2);
        chk("same_press_en", 32'(en), 1);
        cyc(8'b0010_0000, 0, 0);
        chk("release_switch_note", 32'(note), 5);
        chk("release_switch_en", 32'(en), 1);
        cyc(8'h00, 0, 0);
        chk("release_all_en", 32'(en), 0);
        chk("release_all_note", 32'(note), 5);

        // Record overflow
        cyc(8'h00, 1, 0);
        foreach (seq[i]) begin
            cyc(8'(1 << seq[i]), 1, 0);
            cyc(8'h00, 1, 0);
        end
        chk("overflow_count", 32'(cnt), 4);
        chk("overflow_full", 32'(full), 1);
        chk("model_buf_size", 32'(m_buf.size()), 4);
        for (int i = 0; i < 4; i++) chk("model_buf_entry", 32'(m_buf[i]), 32'(exp4[i]));
        cyc(8'h00, 0, 0);

        // Replay the full buffer and collect note at each enable rise
        cyc(8'h00, 0, 1);
        prev_en = 0;
        for (int i = 0; i < 45; i++) begin
            if (en && !prev_en) got.push_back(int'(note));
            prev_en = en;
            cyc(8'h00, 0, 0);
        end
        chk("replay_notes", 32'(got.size()), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("replay_note_val", 32'(got[i]), 32'(exp4[i]));
        chk("replay_done_busy", 32'(busy), 0);

        // Reset mid-replay
        cyc(8'h00, 0, 1);
        cyc(8'h00, 0, 0);
        chk("pre_reset_busy", 32'(busy), 1);
        rst_n = 1'b0;
        cyc(8'h00, 0, 0);
        rst_n = 1'b1;
        chk("midreset_en", 32'(en), 0);
        chk("midreset_note", 32'(note), 0);
        chk("midreset_busy", 32'(busy), 0);
        chk("midreset_count", 32'(cnt), 0);
        chk("midreset_full", 32'(full), 0);

        // Replay timing with buffer {3,1}
        cyc(8'h00, 1, 0);
        cyc(8'h08, 1, 0);
        cyc(8'h00, 1, 0);
        cyc(8'h02, 1, 0);
        cyc(8'h00, 0, 0);
        chk("rec2_count", 32'(cnt), 2);
        cyc(8'h00, 0, 1);
        for (int i = 0; i < 20; i++) begin
            tr_en[i] = en; tr_note[i] = int'(note); tr_busy[i] = busy;
            cyc(8'h00, 0, 0);
        end
        n = 0;
        for (int i = 0; i < 4; i++) if (tr_en[i] && tr_note[i] == 3) n++;
        chk("timing_note3_cycles", 32'(n), 4);
        n = 0;
        for (int i = 4; i < 9; i++) if (!tr_en[i]) n++;
        chk("timing_off_cycles", 32'(n), 5);
        n = 0;
        for (int i = 9; i < 13; i++) if (tr_en[i] && tr_note[i] == 1) n++;
        chk("timing_note1_cycles", 32'(n), 4);
        chk("timing_en_after", 32'(tr_en[13]), 0);
        chk("timing_busy_last_gap", 32'(tr_busy[17]), 1);
        chk("timing_busy_end", 32'(tr_busy[18]), 0);

        // Abort in REP_GAP
        cyc(8'h00, 0, 1);
        repeat (7) cyc(8'h00, 0, 0);
        chk("gap_en", 32'(en), 0);
        chk("gap_busy", 32'(busy), 1);
        cyc(8'h40, 0, 0);
        chk("abort_note", 32'(note), 6);
        chk("abort_en", 32'(en), 1);
        chk("abort_busy", 32'(busy), 0);
        cyc(8'h00, 0, 0);
        chk("abort_release_en", 32'(en), 0);

        // Play with empty buffer
        rst_n = 1'b0;
        cyc(8'h00, 0, 0);
        rst_n = 1'b1;
        cyc(8'h00, 0, 1);
        chk("empty_play_busy", 32'(busy), 0);
        chk("empty_play_en", 32'(en), 0);
        cyc(8'h00, 0, 0);
        chk("empty_play_busy2", 32'(busy), 0);

        // Clear/write collision from IDLE, with a prior nonzero entry
        cyc(8'h00, 1, 0);
        cyc(8'h80, 1, 0);
        cyc(8'h00, 0, 0);
        chk("pre_collision_count", 32'(cnt), 1);
        cyc(8'h01, 1, 0);
        chk("collision_count", 32'(cnt), 1);
        chk("collision_note", 32'(note), 0);
        chk("collision_en", 32'(en), 1);
        cyc(8'h00, 0, 0);
        cyc(8'h00, 0, 1);
        chk("collision_replay_busy", 32'(busy), 1);
        chk("collision_replay_note", 32'(note), 0);
        repeat (12) cyc(8'h00, 0, 0);
        chk("collision_replay_done", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
